// File: rtl/pixie_dp_back_end.sv
// pixie_dp_back_end: scans the 1 KiB Pixie frame buffer into a 64x128 pixel stream with raster sync/blank
module pixie_dp_back_end #(
  parameter int H_TOTAL        = 112,
  parameter int V_TOTAL        = 262,
  parameter int H_ACTIVE_START = 8,
  parameter int V_ACTIVE_START = 80,
  parameter int V_ACTIVE_LINES = 128,
  parameter int HSYNC_START    = 88,
  parameter int HSYNC_LEN      = 12,
  parameter int VSYNC_START    = 240,
  parameter int VSYNC_LEN      = 3
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       clk_enable,
  input  logic       disp_enable,
  output logic [9:0] mem_addr,
  output logic       mem_rd_en,
  input  logic [7:0] mem_rd_data,
  output logic       video,
  output logic       hsync,
  output logic       vsync,
  output logic       hblank,
  output logic       vblank,
  output logic       frame_start
);
  logic [6:0] h, hn, hf;
  logic [8:0] v, vn, vrel;
  logic       h_wrap, f_wrap, h_act, v_act, byte_start, fetch, frame_en, cap;
  logic [7:0] staging, shifter, load;
  always_comb begin
    h_wrap     = h == 7'(H_TOTAL - 1);
    f_wrap     = h_wrap && v == 9'(V_TOTAL - 1);
    hn         = h_wrap ? 7'd0 : h + 7'd1;
    vn         = f_wrap ? 9'd0 : h_wrap ? v + 9'd1 : v;
    vrel       = vn - 9'(V_ACTIVE_START);
    hf         = hn + 7'd1 - 7'(H_ACTIVE_START);
    h_act      = hn >= 7'(H_ACTIVE_START) && hn < 7'(H_ACTIVE_START + 64);
    v_act      = vn >= 9'(V_ACTIVE_START) && vn < 9'(V_ACTIVE_START + V_ACTIVE_LINES);
    byte_start = h_act && 3'(hn - 7'(H_ACTIVE_START)) == 3'd0;
    // fetch one pixel before each byte start; hf is the pixel offset of the byte being fetched
    fetch      = frame_en && v_act && hf < 7'd64 && hf[2:0] == 3'd0;
    // when the byte start lands on the capture clk, take the read data directly
    load       = cap ? mem_rd_data : staging;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      h           <= '0;
      v           <= '0;
      frame_en    <= 1'b0;
      cap         <= 1'b0;
      staging     <= '0;
      shifter     <= '0;
      mem_addr    <= '0;
      mem_rd_en   <= 1'b0;
      frame_start <= 1'b0;
      video       <= 1'b0;
      hsync       <= 1'b0;
      vsync       <= 1'b0;
      hblank      <= 1'b1;
      vblank      <= 1'b1;
    end else begin
      mem_rd_en   <= clk_enable && fetch;
      frame_start <= clk_enable && f_wrap;
      cap         <= mem_rd_en;
      if (cap) staging <= mem_rd_data;
      if (clk_enable) begin
        h       <= hn;
        v       <= vn;
        if (f_wrap) frame_en <= disp_enable;
        if (fetch) mem_addr <= 10'({vrel, hf[5:3]});
        hblank  <= !h_act;
        vblank  <= !v_act;
        hsync   <= hn >= 7'(HSYNC_START) && hn < 7'(HSYNC_START + HSYNC_LEN);
        vsync   <= vn >= 9'(VSYNC_START) && vn < 9'(VSYNC_START + VSYNC_LEN);
        shifter <= byte_start ? load : shifter << 1;
        video   <= h_act && v_act && frame_en && (byte_start ? load[7] : shifter[6]);
      end
    end
endmodule

// File: tb/tb_pixie_dp_back_end.sv
// tb_pixie_dp_back_end: randomized raster run scored against a pixel-level model of the 64x128 display
module tb_pixie_dp_back_end;
  // vertical timing shortened so two full frames fit the run; horizontal timing and the 128-line image are as built
  localparam int H = 112, V = 134, VAS = 2, VAL = 128, VSS = 131, VSL = 3, F = H * V;
  logic       clk = 1'b0, reset_n = 1'b0, clk_enable = 1'b0, disp_enable = 1'b0;
  logic [9:0] mem_addr;
  logic       mem_rd_en;
  logic [7:0] mem_rd_data = 8'd0;
  logic       video, hsync, vsync, hblank, vblank, frame_start;
  logic [7:0] mem [1024];
  typedef struct packed {logic video, hsync, vsync, hblank, vblank, frame_start;} out_t;
  out_t exp_q[$];
  int   fetch_q[$];
  int   compared = 0, mismatched = 0, p = 0, fetches = 0, last_addr = -1;
  bit   fen = 1'b0, ce_seen = 1'b0;

  pixie_dp_back_end #(.V_TOTAL(V), .V_ACTIVE_START(VAS), .V_ACTIVE_LINES(VAL),
                      .VSYNC_START(VSS), .VSYNC_LEN(VSL)) dut (
    .clk(clk), .reset_n(reset_n), .clk_enable(clk_enable), .disp_enable(disp_enable),
    .mem_addr(mem_addr), .mem_rd_en(mem_rd_en), .mem_rd_data(mem_rd_data),
    .video(video), .hsync(hsync), .vsync(vsync), .hblank(hblank), .vblank(vblank),
    .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  // synchronous RAM: data valid for exactly the clk after the strobe, noise otherwise
  always @(posedge clk) mem_rd_data <= mem_rd_en ? mem[mem_addr] : 8'($urandom);
  always @(posedge clk) ce_seen <= clk_enable;

  function automatic void chk(string n, int a, int e);
    compared++;
    if (a != e) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d (pixel %0d, t=%0t)", n, a, e, p, $time);
    end
  endfunction

  always @(negedge clk) begin
    if (ce_seen) begin
      if (exp_q.size() == 0) chk("pixel_queue_underflow", 1, 0);
      else chk("pixel_outputs", int'({video, hsync, vsync, hblank, vblank, frame_start}), int'(exp_q.pop_front()));
    end
    if (mem_rd_en) begin
      fetches++;
      last_addr = int'(mem_addr);
      if (fetch_q.size() == 0) chk("unexpected_fetch", int'(mem_addr), -1);
      else chk("fetch_addr", int'(mem_addr), fetch_q.pop_front());
    end
  end

  task automatic model_step();
    int h, v, k;
    bit ha, va;
    out_t e;
    p = (p + 1) % F;
    if (p == 0) fen = disp_enable;
    h  = p % H;
    v  = p / H;
    ha = h >= 8 && h < 72;
    va = v >= VAS && v < VAS + VAL;
    k  = (v - VAS) * 64 + (h - 8);
    e.video       = 1'b0;
    if (ha && va && fen) e.video = mem[k / 8][7 - k % 8];
    e.hsync       = h >= 88 && h < 100;
    e.vsync       = v >= VSS && v < VSS + VSL;
    e.hblank      = !ha;
    e.vblank      = !va;
    e.frame_start = p == 0;
    exp_q.push_back(e);
    if (fen && va && h % 8 == 7 && h < 64) fetch_q.push_back((v - VAS) * 8 + h / 8);
  endtask

  task automatic tick(input bit en);
    clk_enable = en;
    if (en) model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      tick(1'b1);
      tick(1'b0);
      if ($urandom_range(7) == 0) tick(1'b0);
    end
  endtask

  task automatic check_reset(string n);
    chk(n, int'({video, hsync, vsync, hblank, vblank, mem_rd_en, frame_start}), int'(7'b0001100));
    chk({n, "_addr"}, int'(mem_addr), 0);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 8'($urandom);
    mem[0] = 8'hA5;
    #12;
    check_reset("reset_state");
    reset_n = 1'b1;
    tick(1'b0);
    disp_enable = 1'b1;
    run(F);
    chk("frame0_fetches", fetches, 0);
    fetches = 0;
    run(F / 2);
    disp_enable = 1'b0;
    run(F - F / 2);
    chk("frame1_fetches", fetches, 1024);
    chk("frame1_last_addr", last_addr, 1023);
    fetches = 0;
    run(5 * H);
    disp_enable = 1'b1;
    run(5 * H + 40);
    chk("frame2_fetches", fetches, 0);
    #5;
    reset_n = 1'b0;
    #1;
    check_reset("async_reset");
    chk("queues_at_reset", exp_q.size() + fetch_q.size(), 0);
    repeat (2) @(posedge clk);
    #3;
    check_reset("held_reset");
    reset_n = 1'b1;
    p   = 0;
    fen = 1'b0;
    fetches = 0;
    tick(1'b0);
    run(4 * H);
    chk("post_reset_fetches", fetches, 0);
    tick(1'b0);
    tick(1'b0);
    chk("queues_drained", exp_q.size() + fetch_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/pixie_dp_back_end.md
Name: pixie_dp_back_end

Overview:
- Read side of the Pixie display frame buffer: scans the 1024-byte buffer written by the Pixie DMA front end and serialises it into a 64x128 monochrome pixel stream.
- Generates horizontal/vertical sync and blank for the video output stage.
- Runs on the system clock, advancing one pixel per clk_enable; fixed 262-line, 112-pixel-per-line raster matching the 14-byte-time Pixie line.

Parameters:
- H_TOTAL, 112, pixel clocks per line (14 byte-times x 8).
- V_TOTAL, 262, lines per frame.
- H_ACTIVE_START, 8, first active pixel (byte-time 1).
- V_ACTIVE_START, 80, first active line.
- V_ACTIVE_LINES, 128, active lines (8 bytes each, 1024 total).
- HSYNC_START, 88, first hsync pixel.
- HSYNC_LEN, 12, hsync width in pixels.
- VSYNC_START, 240, first vsync line.
- VSYNC_LEN, 3, vsync width in lines.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- clk_enable  in  1  pixel-rate enable; never asserted on two consecutive clk cycles.
- disp_enable  in  1  display enable from the Pixie control logic; sampled once per frame.
- mem_addr  out  10  frame buffer read address.
- mem_rd_en  out  1  read strobe; one clk pulse per fetch.
- mem_rd_data  in  8  frame buffer data; valid exactly one clk after mem_rd_en.
- video  out  1  pixel, 1 = lit.
- hsync  out  1  active-high horizontal sync.
- vsync  out  1  active-high vertical sync.
- hblank  out  1  high outside the active pixel window.
- vblank  out  1  high outside the active line window.
- frame_start  out  1  one-clk pulse when the raster wraps to line 0, pixel 0.

Behaviour:
- Reset (async, reset_n=0):
  - h_count=0, v_count=0, shifter=0, fetch byte index=0, frame enable=0.
  - Outputs video=0, hsync=0, vsync=0, hblank=1, vblank=1, mem_addr=0, mem_rd_en=0, frame_start=0.
- Counters:
  - h_count advances on clk_enable and wraps H_TOTAL-1 -> 0.
  - On that wrap, v_count advances and wraps V_TOTAL-1 -> 0.
  - No activity between enables.
- Frame enable:
  - Latched from disp_enable on the clk_enable that moves the raster to (0,0).
  - frame_start pulses on that same clk.
  - A change in disp_enable mid-frame has no effect until the next wrap.
- Active window:
  - h in [H_ACTIVE_START, H_ACTIVE_START+63].
  - v in [V_ACTIVE_START, V_ACTIVE_START+V_ACTIVE_LINES-1].
  - hblank/vblank are the registered complements of the two window conditions, updated on clk_enable, aligned with the pixel they describe.
- Address:
  - mem_addr = (v - V_ACTIVE_START)*8 + byte, byte 0..7, 10-bit, no carry out.
  - Last active line, byte 7 = 1023.
- Fetch:
  - On the clk_enable that makes h = H_ACTIVE_START+8*byte-1 (byte 0..7), on an active line with frame enable set, register mem_addr and pulse mem_rd_en for one clk.
  - Capture mem_rd_data the next clk into a staging register.
  - Exactly 8 fetches per active line, 1024 per enabled frame, none otherwise.
- Shift:
  - On the clk_enable entering each byte start, shifter <= staging.
  - video <= staging[7] when active and enabled, else 0.
  - Subsequent enables shift left, outputting bits 6..0, MSB first.
  - Pixel k of a line is byte k/8, bit 7-(k%8).
- Blanking: video forced 0 whenever hblank or vblank would be 1, or frame enable is 0.
- Syncs (registered on clk_enable):
  - hsync=1 for h in [HSYNC_START, HSYNC_START+HSYNC_LEN-1].
  - vsync=1 for v in [VSYNC_START, VSYNC_START+VSYNC_LEN-1].
  - Syncs run regardless of disp_enable.
- Output latency: all raster outputs are one clk after the clk_enable that produced the corresponding counter value.
- Reset mid-line: everything returns to reset values immediately. After release, the raster restarts at (0,0) with no fetches until the next active line.

Test Plan:
- Reset release, clk_enable every 2nd clk, disp_enable=1 -> first frame_start after 112*262 enables; hsync high 12 pixels/line; vsync high lines 240-242; vblank low lines 80-207 only.
- Buffer filled with addr[7:0] -> line 80 fetches addresses 0..7, line 207 fetches 1016..1023; mem_rd_en pulses 8 per line, 1024 per frame.
- Buffer byte 0 = 0xA5, others 0 -> line 80 pixels 8..15 = 1,0,1,0,0,1,0,1; all other pixels 0.
- disp_enable=0 for a whole frame -> video=0, mem_rd_en never pulses, syncs/blanks unchanged; disp_enable raised mid-frame -> no effect until next frame_start.
- clk_enable every 3rd clk with random gaps -> same pixel sequence as the regular-rate run; mem_rd_data captured exactly one clk after mem_rd_en.
- reset_n pulsed low during line 100, pixel 40 -> outputs at reset values asynchronously; after release the raster restarts at (0,0) and the first fetch is address 0 on line 80.
